// File: rtl/teak_hs_sync_receiver_if.sv
// Channel bundle for teak_hs_sync_receiver: async four-phase request/ack with bundled data,
// plus the synchronous valid/ready output port. Names are from the receiver's point of view.
interface teak_hs_sync_receiver_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             req_i;
  logic [WIDTH-1:0] data_i;
  logic             ack_o;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  // Initiator/sink side: drives the async request, bundled data and downstream ready.
  modport master (
    output req_i,
    output data_i,
    output out_ready,
    input  ack_o,
    input  out_valid,
    input  out_data
  );

  // Receiver side.
  modport slave (
    input  req_i,
    input  data_i,
    input  out_ready,
    output ack_o,
    output out_valid,
    output out_data
  );
endinterface

// File: rtl/teak_hs_sync_receiver.sv
// Clocked responder for a four-phase bundled-data channel: synchronises req, captures data,
// offers it on valid/ready and returns ack. Define TEAK_HS_RX_EARLY_ACK_EN for early ack.
module teak_hs_sync_receiver #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned SYNC_STAGES = 2   // legal range 2..4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  teak_hs_sync_receiver_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle,
    StHold,
    StAcked
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] prime_q;
  logic                   rearm_q, rearm_d;
  logic                   ack_q, ack_d;
  logic                   valid_q, valid_d;
  logic [WIDTH-1:0]       data_q, data_d;
  logic                   req_s;
  logic                   primed;

  assign req_s  = sync_q[SYNC_STAGES-1];
  // The cleared synchroniser reads 0 after reset without having observed req_i; rearm may
  // only be released once the chain holds genuine samples, so a stale high req is not taken.
  assign primed = prime_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '0;
      prime_q <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.req_i};
      prime_q <= {prime_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  always_comb begin
    state_d = state_q;
    rearm_d = rearm_q;
    ack_d   = ack_q;
    valid_d = valid_q;
    data_d  = data_q;

`ifdef TEAK_HS_RX_EARLY_ACK_EN
    // The output buffer drains independently of the async return-to-zero.
    if (valid_q && bus.out_ready) begin
      valid_d = 1'b0;
    end
    unique case (state_q)
      StIdle: begin
        if (!req_s && primed) begin
          rearm_d = 1'b0;
        end
        if (req_s && !rearm_q && (!valid_q || bus.out_ready)) begin
          data_d  = bus.data_i;
          valid_d = 1'b1;
          ack_d   = 1'b1;
          state_d = StAcked;
        end
      end
      StAcked: begin
        if (!req_s) begin
          ack_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
`else
    unique case (state_q)
      StIdle: begin
        if (!req_s && primed) begin
          rearm_d = 1'b0;
        end
        if (req_s && !rearm_q && !valid_q) begin
          data_d  = bus.data_i;
          valid_d = 1'b1;
          state_d = StHold;
        end
      end
      // A req that drops early is ignored here: ack still waits for the word to be taken.
      StHold: begin
        if (valid_q && bus.out_ready) begin
          valid_d = 1'b0;
          ack_d   = 1'b1;
          state_d = StAcked;
        end
      end
      StAcked: begin
        if (!req_s) begin
          ack_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      rearm_q <= 1'b1;
      ack_q   <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      rearm_q <= rearm_d;
      ack_q   <= ack_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign bus.ack_o     = ack_q;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;

`ifndef SYNTHESIS
  a_stall_hold: assert property (@(posedge clk) disable iff (!reset_n)
    (valid_q && !bus.out_ready) |=> (valid_q && $stable(data_q)));
  a_ack_state: assert property (@(posedge clk) disable iff (!reset_n)
    ack_q == (state_q == StAcked));
`endif

endmodule

// File: tb/tb_teak_hs_sync_receiver.sv
// Self-checking bench for teak_hs_sync_receiver: cycle vector table, hand-written corner
// sequences and randomized four-phase bursts checked against an in-order word scoreboard.
module tb_teak_hs_sync_receiver;

  localparam int unsigned W    = 32;
  localparam int unsigned SYNC = 2;
`ifdef TEAK_HS_RX_EARLY_ACK_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_pass   = 0;

  teak_hs_sync_receiver_if #(.WIDTH(W)) bus ();

  teak_hs_sync_receiver #(.WIDTH(W), .SYNC_STAGES(SYNC)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // Cycle vectors: inputs applied before an edge, outputs compared just after it.
  typedef struct {
    logic         req;
    logic [W-1:0] data;
    logic         ready;
    logic         exp_ack;
    logic         exp_valid;
    logic [W-1:0] exp_data;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic [W-1:0] d, input logic rdy,
                              input logic ea, input logic ev, input logic [W-1:0] ed);
    vec_t v;
    v.req = r; v.data = d; v.ready = rdy;
    v.exp_ack = ea; v.exp_valid = ev; v.exp_data = ed;
    return v;
  endfunction

  // Sink-side monitor and scoreboard state.
  logic [W-1:0] got_q[$];
  logic [W-1:0] exp_q[$];
  bit           mon_en = 1'b0;
  bit           rnd_en = 1'b0;
  logic         ack_prev;
  int           ack_toggles;
  int           stall_err;
  bit           stall_pend;
  logic [W-1:0] stall_data;

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.out_valid && bus.out_ready) got_q.push_back(bus.out_data);
      if (bus.ack_o !== ack_prev) ack_toggles++;
      ack_prev = bus.ack_o;
      if (stall_pend && !(bus.out_valid && bus.out_data == stall_data)) stall_err++;
      stall_pend = bus.out_valid && !bus.out_ready;
      stall_data = bus.out_data;
    end
  end

  task automatic send_word(input logic [W-1:0] w);
    bit seen;
    bus.data_i = w;
    repeat ($urandom_range(0, 2)) tick();
    bus.req_i = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 300; k++) begin
      tick();
      if (bus.ack_o) begin seen = 1'b1; break; end
    end
    check("burst ack rise", 64'(seen), 64'd1);
    bus.data_i = $urandom();  // bundling window closed once ack is high
    repeat ($urandom_range(0, 2)) tick();
    bus.req_i = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (!bus.ack_o) begin seen = 1'b1; break; end
    end
    check("burst ack fall", 64'(seen), 64'd1);
    repeat ($urandom_range(0, 2)) tick();
  endtask

  task automatic run_burst(input int n, input bit rnd_data, input string tag);
    logic [W-1:0] w;
    got_q.delete();
    exp_q.delete();
    ack_toggles = 0;
    stall_err   = 0;
    stall_pend  = 1'b0;
    ack_prev    = bus.ack_o;
    mon_en      = 1'b1;
    rnd_en      = 1'b1;
    fork
      begin
        for (int i = 0; i < n; i++) begin
          w = rnd_data ? W'($urandom()) : W'(i);
          exp_q.push_back(w);
          send_word(w);
        end
        rnd_en = 1'b0;
      end
      begin
        while (rnd_en) begin
          tick();
          if (rnd_en) bus.out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    bus.out_ready = 1'b1;
    repeat (4) tick();
    mon_en = 1'b0;
    check($sformatf("%s word count", tag), 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s word %0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
    check($sformatf("%s ack toggles", tag), 64'(ack_toggles), 64'(2 * n));
    check($sformatf("%s stall stability", tag), 64'(stall_err), 64'd0);
  endtask

  initial begin
    int  lat;
    int  pulses;
    int  ack_rises;
    bit  seen;
    logic vprev, aprev;

    reset_n       = 1'b0;
    bus.req_i     = 1'b0;
    bus.data_i    = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset ack", 64'(bus.ack_o), 64'd0);
    check("reset valid", 64'(bus.out_valid), 64'd0);
    check("reset data", 64'(bus.out_data), 64'd0);
    reset_n = 1'b1;

    // Single transfer, ready held high.
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1'b0, '0, 1'b1, 1'b0, 1'b0, '0));
    tbl.push_back(mk(1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, '0));
    tbl.push_back(mk(1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, '0));
    tbl.push_back(mk(1'b1, 32'hDEADBEEF, 1'b1, EARLY, 1'b1, 32'hDEADBEEF));
    tbl.push_back(mk(1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 32'hDEADBEEF));
    tbl.push_back(mk(1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 32'hDEADBEEF));
    tbl.push_back(mk(1'b0, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 32'hDEADBEEF));
    tbl.push_back(mk(1'b0, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 32'hDEADBEEF));
    tbl.push_back(mk(1'b0, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF));
    tbl.push_back(mk(1'b0, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF));
    foreach (tbl[i]) begin
      bus.req_i     = tbl[i].req;
      bus.data_i    = tbl[i].data;
      bus.out_ready = tbl[i].ready;
      tick();
      check($sformatf("vec%0d ack", i), 64'(bus.ack_o), 64'(tbl[i].exp_ack));
      check($sformatf("vec%0d valid", i), 64'(bus.out_valid), 64'(tbl[i].exp_valid));
      check($sformatf("vec%0d data", i), 64'(bus.out_data), 64'(tbl[i].exp_data));
    end

`ifndef TEAK_HS_RX_EARLY_ACK_EN
    // Backpressure: word must sit still for 20 stalled cycles with no ack.
    bus.out_ready = 1'b0;
    bus.data_i    = 32'h55;
    bus.req_i     = 1'b1;
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (bus.out_valid) begin lat = k; break; end
    end
    check("bp valid latency ok", 64'(lat >= 1 && lat <= SYNC + 1), 64'd1);
    for (int k = 0; k < 20; k++) begin
      tick();
      check($sformatf("bp hold %0d", k),
            64'(bus.out_valid == 1'b1 && bus.out_data == 32'h55 && bus.ack_o == 1'b0), 64'd1);
    end
    bus.out_ready = 1'b1;
    tick();
    check("bp ack after accept", 64'(bus.ack_o), 64'd1);
    check("bp valid after accept", 64'(bus.out_valid), 64'd0);
    bus.req_i = 1'b0;
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (!bus.ack_o) begin lat = k; break; end
    end
    check("bp ack fall latency ok", 64'(lat >= 1 && lat <= SYNC + 1), 64'd1);
`else
    // Early ack: ack while the word is still stalled downstream; second word waits.
    bus.out_ready = 1'b0;
    bus.data_i    = 32'hA;
    bus.req_i     = 1'b1;
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (bus.ack_o) begin lat = k; break; end
    end
    check("early ack latency", 64'(lat), 64'(SYNC + 1));
    check("early valid with ack", 64'(bus.out_valid), 64'd1);
    check("early data A", 64'(bus.out_data), 64'hA);
    bus.req_i = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (!bus.ack_o) begin seen = 1'b1; break; end
    end
    check("early ack fall", 64'(seen), 64'd1);
    bus.data_i = 32'hB;
    bus.req_i  = 1'b1;
    repeat (8) tick();
    check("early B blocked", 64'(bus.out_valid == 1'b1 && bus.out_data == 32'hA &&
                                 bus.ack_o == 1'b0), 64'd1);
    bus.out_ready = 1'b1;
    tick();
    check("early B captured on A accept", 64'(bus.out_data), 64'hB);
    check("early B valid", 64'(bus.out_valid), 64'd1);
    check("early B ack", 64'(bus.ack_o), 64'd1);
    tick();
    check("early B consumed", 64'(bus.out_valid), 64'd0);
    bus.req_i = 1'b0;
    repeat (5) tick();
    check("early idle ack", 64'(bus.ack_o), 64'd0);
`endif

    // Protocol violation: req pulsed for one cycle only.
    bus.out_ready = 1'b1;
    bus.data_i    = 32'h77;
    bus.req_i     = 1'b1;
    tick();
    bus.req_i = 1'b0;
    pulses = 0; ack_rises = 0; vprev = bus.out_valid; aprev = bus.ack_o;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (bus.out_valid && !vprev) pulses++;
      if (bus.ack_o && !aprev) ack_rises++;
      vprev = bus.out_valid;
      aprev = bus.ack_o;
    end
    check("viol at most one word", 64'(pulses <= 1), 64'd1);
    check("viol no ack without word", 64'(ack_rises <= pulses), 64'd1);
    check("viol ack returns low", 64'(bus.ack_o), 64'd0);

    // Reset mid-handshake with req held high: stale req must not be re-captured.
    bus.out_ready = 1'b0;
    bus.data_i    = 32'hCAFE;
    bus.req_i     = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (bus.out_valid) begin seen = 1'b1; break; end
    end
    check("rst pre word valid", 64'(seen), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("rst async ack", 64'(bus.ack_o), 64'd0);
    check("rst async valid", 64'(bus.out_valid), 64'd0);
    check("rst async data", 64'(bus.out_data), 64'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    bus.out_ready = 1'b1;
    pulses = 0; ack_rises = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (bus.out_valid) pulses++;
      if (bus.ack_o) ack_rises++;
    end
    check("rst stale req ignored", 64'(pulses), 64'd0);
    check("rst stale no ack", 64'(ack_rises), 64'd0);
    bus.req_i = 1'b0;
    repeat (4) tick();
    bus.data_i = 32'h12345678;
    bus.req_i  = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (bus.out_valid) begin seen = 1'b1; break; end
    end
    check("rst new word valid", 64'(seen), 64'd1);
    check("rst new word data", 64'(bus.out_data), 64'h12345678);
    pulses = 1;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (bus.out_valid) pulses++;
    end
    check("rst new word once", 64'(pulses), 64'd1);
    bus.req_i = 1'b0;
    repeat (5) tick();
    check("rst ack returns low", 64'(bus.ack_o), 64'd0);

    // Randomized four-phase traffic against the in-order scoreboard.
    run_burst(8, 1'b0, "burst8");
    run_burst(24, 1'b1, "rand24");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
